// File: rtl/score_ram_pkg.sv
// Shared types and constants for the score/level RAM responder.
// Holds the responder FSM state type, default widths, the user slot
// addresses with their user ids, and the game_state codes that go with them.
package score_ram_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;
   localparam int DEPTH_DEF  = 16;

   // Responder FSM: wipe every location after reset, then serve requests.
   typedef enum logic {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } state_t;

   // One level byte per user slot.
   localparam logic [7:0] USER_C = 8'd0;
   localparam logic [7:0] USER_3 = 8'd1;
   localparam logic [7:0] USER_D = 8'd2;
   localparam logic [7:0] USER_4 = 8'd3;

   // User ids as seen on the keypad side.
   localparam logic [3:0] USER_C_ID = 4'b1100;
   localparam logic [3:0] USER_3_ID = 4'b0011;
   localparam logic [3:0] USER_D_ID = 4'b1101;
   localparam logic [3:0] USER_4_ID = 4'b0100;

   // game_state codes that drive level traffic to this store.
   localparam logic [7:0] GS_LEVEL_UP   = 8'h20;
   localparam logic [7:0] GS_SHOW_LEVEL = 8'h30;

   // Map a user id to its slot address; unknown ids fall back to slot 0.
   function automatic logic [7:0] user_slot(input logic [3:0] id);
      logic [7:0] slot;
      case (id)
         USER_3_ID: slot = USER_3;
         USER_D_ID: slot = USER_D;
         USER_4_ID: slot = USER_4;
         default:   slot = USER_C;
      endcase
      return slot;
   endfunction

endpackage

// File: rtl/score_ram_responder_if.sv
// Request/response bundle between the RAM controller (master) and the
// score RAM responder (slave). Names follow the responder's point of view.
interface score_ram_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address_in;
   logic              r_w;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic              rd_valid;
   logic              wr_ack;
   logic              oor_err;

   modport master (
      output address_in, r_w, data_in,
      input  data_out, busy, rd_valid, wr_ack, oor_err
   );

   modport slave (
      input  address_in, r_w, data_in,
      output data_out, busy, rd_valid, wr_ack, oor_err
   );
endinterface

// File: rtl/score_ram_clear_seq.sv
// Post-reset clear sequencer: walks clr_ptr over every location, asking for
// one CLEAR_VAL write per cycle, then parks in SERVE until the next reset.
// clr_ptr stops at DEPTH-1 and therefore never wraps.
module score_ram_clear_seq
   import score_ram_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   output logic             clr_we,
   output logic [PTR_W-1:0] clr_addr,
   output logic             busy,
   output logic             done
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   state_t           state_reg,   state_next;
   logic [PTR_W-1:0] clr_ptr_reg, clr_ptr_next;

   // State and pointer registers; any reset restarts the wipe at location 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= CLEAR;
         clr_ptr_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_ptr_reg <= clr_ptr_next;
      end
   end

   // Next state: one write per cycle in CLEAR, leave after the last location.
   always_comb begin
      state_next   = state_reg;
      clr_ptr_next = clr_ptr_reg;
      clr_we       = 1'b0;
      case (state_reg)
         CLEAR: begin
            clr_we = 1'b1;
            if (clr_ptr_reg == LAST_PTR) begin
               state_next = SERVE;
            end else begin
               clr_ptr_next = clr_ptr_reg + 1'b1;
            end
         end
         SERVE: begin
            state_next = SERVE;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   assign clr_addr = clr_ptr_reg;
   assign busy     = (state_reg == CLEAR);
   assign done     = (state_reg == SERVE);

endmodule

// File: rtl/score_ram_responder.sv
// RAM-side responder for the score/level store. Every clk edge in SERVE is a
// request: read (r_w=0) or write (r_w=1) at address_in. After each reset the
// store is wiped to CLEAR_VAL, one location per cycle, with busy high.
// Optional build macro: HIGH_SCORE_ONLY_EN -- a write commits only when the
// new value is strictly greater (unsigned) than the stored one.
module score_ram_responder
   import score_ram_pkg::*;
#(
   parameter int                DEPTH     = DEPTH_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   score_ram_responder_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   // DEPTH widened by one bit so address compares run at full address width.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic             clr_we;
   logic [PTR_W-1:0] clr_addr;
   logic             seq_busy;
   logic             serve;

   logic             in_range;
   logic [PTR_W-1:0] idx;
   logic [DATA_W-1:0] mem_rd;
   logic             wr_commit;

   logic             we;
   logic [PTR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   logic [DATA_W-1:0] data_out_reg;
   logic             rd_valid_reg;
   logic             wr_ack_reg;
   logic             oor_err_reg;

   score_ram_clear_seq #(
      .DEPTH (DEPTH)
   ) u_clear_seq (
      .clk      (clk),
      .reset    (reset),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (seq_busy),
      .done     (serve)
   );

   assign in_range = ({1'b0, bus.address_in} < DEPTH_X);
   assign idx      = bus.address_in[PTR_W-1:0];
   assign mem_rd   = mem[idx];

`ifdef HIGH_SCORE_ONLY_EN
   // Only a strictly higher score replaces the stored one.
   assign wr_commit = serve && bus.r_w && in_range && (bus.data_in > mem_rd);
`else
   assign wr_commit = serve && bus.r_w && in_range;
`endif

   // Single write port: clear sequencer has priority, otherwise the request.
   always_comb begin
      we    = 1'b0;
      waddr = idx;
      wdata = bus.data_in;
      if (clr_we) begin
         we    = 1'b1;
         waddr = clr_addr;
         wdata = CLEAR_VAL;
      end else if (wr_commit) begin
         we = 1'b1;
      end
   end

   // Storage array; contents are rebuilt by the clear sequence, not by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered response: read data, valid and the one-cycle status pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_reg <= '0;
         rd_valid_reg <= 1'b0;
         wr_ack_reg   <= 1'b0;
         oor_err_reg  <= 1'b0;
      end else if (!serve) begin
         data_out_reg <= '0;
         rd_valid_reg <= 1'b0;
         wr_ack_reg   <= 1'b0;
         oor_err_reg  <= 1'b0;
      end else begin
         rd_valid_reg <= !bus.r_w;
         wr_ack_reg   <= wr_commit;
         oor_err_reg  <= !in_range;
         if (!bus.r_w) begin
            data_out_reg <= in_range ? mem_rd : '0;
         end
      end
   end

   assign bus.data_out = data_out_reg;
   assign bus.rd_valid = rd_valid_reg;
   assign bus.wr_ack   = wr_ack_reg;
   assign bus.oor_err  = oor_err_reg;
   assign bus.busy     = seq_busy;

endmodule

// File: tb/tb_score_ram_responder.sv
// Self-checking bench for score_ram_responder: directed scenarios followed by
// random traffic (with occasional resets) against a cycle-level reference.
module tb_score_ram_responder;
   import score_ram_pkg::*;

   localparam int         DEPTH  = 16;
   localparam int         DATA_W = 8;
   localparam int         ADDR_W = 8;
   localparam logic [7:0] CLR    = 8'h00;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   score_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   score_ram_responder #(
      .DEPTH     (DEPTH),
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .CLEAR_VAL (CLR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: stored bytes, remaining clear cycles, expected outputs.
   logic [7:0] model_mem [DEPTH];
   int         clear_left;
   logic [7:0] exp_dout;
   logic       exp_rdv, exp_ack, exp_oor, exp_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = CLR;
      exp_dout = 8'h00;
      exp_rdv  = 1'b0;
      exp_ack  = 1'b0;
      exp_oor  = 1'b0;
      exp_busy = 1'b1;
   endtask

   // One clock edge of the store's behaviour, from the request rules.
   task automatic model_edge(input logic rw, input int addr, input logic [7:0] din);
      bit inr;
      bit commit;
      exp_rdv = 1'b0;
      exp_ack = 1'b0;
      exp_oor = 1'b0;
      if (clear_left > 0) begin
         clear_left--;
         exp_dout = 8'h00;
         exp_busy = (clear_left > 0);
      end else begin
         exp_busy = 1'b0;
         inr      = (addr < DEPTH);
         exp_oor  = !inr;
         if (!rw) begin
            exp_rdv  = 1'b1;
            exp_dout = inr ? model_mem[addr] : 8'h00;
         end else if (inr) begin
`ifdef HIGH_SCORE_ONLY_EN
            commit = (din > model_mem[addr]);
`else
            commit = 1'b1;
`endif
            if (commit) begin
               model_mem[addr] = din;
               exp_ack = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".data_out"}, bus.data_out, exp_dout);
      check({tag, ".busy"},     bus.busy,     exp_busy);
      check({tag, ".rd_valid"}, bus.rd_valid, exp_rdv);
      check({tag, ".wr_ack"},   bus.wr_ack,   exp_ack);
      check({tag, ".oor_err"},  bus.oor_err,  exp_oor);
   endtask

   // Drive one request, let one edge pass, compare all outputs.
   task automatic do_cycle(input logic rw, input int addr, input logic [7:0] din, input string tag);
      bus.r_w        = rw;
      bus.address_in = ADDR_W'(addr);
      bus.data_in    = din;
      @(posedge clk);
      model_edge(rw, addr, din);
      #1;
      $display("[TB] %s rw=%0d addr=%02h din=%02h -> dout=%02h busy=%0d rdv=%0d ack=%0d oor=%0d",
               tag, rw, addr, din, bus.data_out, bus.busy, bus.rd_valid, bus.wr_ack, bus.oor_err);
      check_outputs(tag);
   endtask

   // Assert reset off-edge (checks the asynchronous effect), hold, release.
   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      repeat (cycles) begin
         @(posedge clk);
         #1;
         check_outputs("rst_hold");
      end
      reset = 1'b0;
   endtask

   initial begin
      bus.r_w        = 1'b0;
      bus.address_in = '0;
      bus.data_in    = '0;
      reset          = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("por");
      reset = 1'b0;

      // 1: clear takes DEPTH cycles, first read lands the cycle after busy falls.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 0, 8'h00, "t1_clear");
      check("t1_busy_low", bus.busy, 1'b0);
      do_cycle(1'b0, 0, 8'h00, "t1_first_rd");
      check("t1_rdv", bus.rd_valid, 1'b1);
      check("t1_dout", bus.data_out, 8'h00);

      // 2: write then read a user slot.
      do_cycle(1'b1, int'(USER_D), 8'h05, "t2_wr");
      check("t2_ack", bus.wr_ack, 1'b1);
      do_cycle(1'b0, int'(USER_D), 8'h00, "t2_rd");
      check("t2_rd", bus.data_out, 8'h05);

      // 3: out-of-range write and read leave the array untouched.
      do_cycle(1'b1, 8'h10, 8'hAA, "t3_wr_oor");
      check("t3_oor_wr", bus.oor_err, 1'b1);
      check("t3_ack", bus.wr_ack, 1'b0);
      do_cycle(1'b0, 8'h10, 8'h00, "t3_rd_oor");
      check("t3_rd_dout", bus.data_out, 8'h00);
      check("t3_oor_rd", bus.oor_err, 1'b1);
      for (int a = 0; a < DEPTH; a++) begin
         do_cycle(1'b0, a, 8'h00, "t3_scan");
         check("t3_noaa", (bus.data_out == 8'hAA), 1'b0);
      end

      // 4: reset wipes a written location.
      do_cycle(1'b1, 1, 8'h07, "t4_wr");
      apply_reset(1);
      check("t4_busy", bus.busy, 1'b1);
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1, 8'h00, "t4_clear");
      do_cycle(1'b0, 1, 8'h00, "t4_rd");
      check("t4_rd", bus.data_out, 8'h00);

      // 5: lower second write is rejected only with the high-score option.
      do_cycle(1'b1, 0, 8'h09, "t5_wr_hi");
      do_cycle(1'b1, 0, 8'h04, "t5_wr_lo");
`ifdef HIGH_SCORE_ONLY_EN
      check("t5_ack", bus.wr_ack, 1'b0);
`else
      check("t5_ack", bus.wr_ack, 1'b1);
`endif
      do_cycle(1'b0, 0, 8'h00, "t5_rd");
`ifdef HIGH_SCORE_ONLY_EN
      check("t5_rd", bus.data_out, 8'h09);
`else
      check("t5_rd", bus.data_out, 8'h04);
`endif

      // 6: alternate write/read each cycle across the user slots.
      apply_reset(1);
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 0, 8'h00, "t6_clear");
      for (int k = 0; k < 4; k++) begin
         do_cycle(1'b1, k, 8'(k + 1), "t6_wr");
         do_cycle(1'b0, k, 8'h00, "t6_rd");
         check("t6_rd", bus.data_out, 32'(k + 1));
      end

      // Random traffic, including addresses past DEPTH and resets mid-stream.
      for (int n = 0; n < 600; n++) begin
         int   addr;
         logic rw;
         if ($urandom_range(0, 99) < 2) begin
            apply_reset(int'($urandom_range(1, 2)));
         end else begin
            addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 19));
            rw   = 1'($urandom_range(0, 1));
            do_cycle(rw, addr, 8'($urandom), "rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
